// File: rtl/xenoa_temporal_sched.sv
// XENOA temporal alignment front end: timestamp triple collector
// plus round-robin causal-chain arbiter with minimum issue spacing.
module xenoa_temporal_sched #(
    parameter int NUM_REQ   = 4,
    parameter int TS_W      = 64,
    parameter int CID_W     = 128,
    parameter int TIMEOUT   = 16,
    parameter int TS_GAP    = 2,
    parameter int CHAIN_GAP = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dev_valid,
    input  logic [TS_W-1:0]            dev_ts,
    output logic                       dev_ready,
    input  logic                       fab_valid,
    input  logic [TS_W-1:0]            fab_ts,
    output logic                       fab_ready,
    input  logic                       cld_valid,
    input  logic [TS_W-1:0]            cld_ts,
    output logic                       cld_ready,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*CID_W-1:0]   req_chain_id,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [TS_W-1:0]            device_timestamp,
    output logic [TS_W-1:0]            fabric_timestamp,
    output logic [TS_W-1:0]            cloud_timestamp,
    output logic                       timestamp_valid,
    output logic [CID_W-1:0]           parent_chain_id,
    output logic                       chain_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       ts_timeout,
    output logic [2:0]                 partial_mask
);

    localparam int PW  = $clog2(NUM_REQ);
    localparam int TMW = $clog2(TIMEOUT + 1);
    localparam int GPW = $clog2(TS_GAP + 2);
    localparam int CGW = $clog2(CHAIN_GAP + 1);

    localparam logic [TMW-1:0] TMR_LAST = TMW'(TIMEOUT - 1);
    localparam logic [GPW-1:0] GAP_LAST = GPW'(TS_GAP - 1);
    localparam logic [CGW-1:0] CG_LOAD  = CGW'(CHAIN_GAP - 1);
    localparam logic [PW-1:0]  LAST_REQ = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_GAP
    } ts_state_t;

    ts_state_t        state;
    ts_state_t        nxt;
    logic [TMW-1:0]   tmr;
    logic [GPW-1:0]   gcnt;
    logic [TS_W-1:0]  hold_dev;
    logic [TS_W-1:0]  hold_fab;
    logic [TS_W-1:0]  hold_cld;
    logic [2:0]       cap;
    logic             all_in;
    logic             fire_to;
    logic             open_win;

    logic [PW-1:0]    ptr;
    logic [CGW-1:0]   cg;
    logic [PW-1:0]    grant_g;
    logic             xfer;

    // Requester index i positions after base, wrapping at NUM_REQ.
    function automatic logic [PW-1:0] wrap_idx(
        input logic [PW-1:0] base,
        input int            off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Capture handshakes: a domain is open until its value is held.
    always_comb begin
        open_win  = (state == S_IDLE) || (state == S_COLLECT);
        dev_ready = rst_n & open_win & ~partial_mask[0];
        fab_ready = rst_n & open_win & ~partial_mask[1];
        cld_ready = rst_n & open_win & ~partial_mask[2];
        cap       = {cld_valid & cld_ready,
                     fab_valid & fab_ready,
                     dev_valid & dev_ready};
        all_in    = &(partial_mask | cap);
    end

    // Triple FSM next state; completion takes priority over timeout.
    always_comb begin
        nxt     = state;
        fire_to = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (all_in) nxt = S_ISSUE;
                else if (|cap) nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (all_in) begin
                    nxt = S_ISSUE;
                end else if (tmr == TMR_LAST) begin
                    nxt     = S_IDLE;
                    fire_to = 1'b1;
                end
            end
            S_ISSUE: begin
                nxt = (TS_GAP == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gcnt == GAP_LAST) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Triple FSM state, timers, capture flags and held values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            tmr          <= '0;
            gcnt         <= '0;
            partial_mask <= '0;
            hold_dev     <= '0;
            hold_fab     <= '0;
            hold_cld     <= '0;
        end else begin
            state <= nxt;
            tmr   <= (state == S_COLLECT) ? tmr + TMW'(1) : '0;
            gcnt  <= (state == S_GAP) ? gcnt + GPW'(1) : '0;
            if (nxt == S_ISSUE || fire_to) partial_mask <= '0;
            else partial_mask <= partial_mask | cap;
            if (cap[0]) hold_dev <= dev_ts;
            if (cap[1]) hold_fab <= fab_ts;
            if (cap[2]) hold_cld <= cld_ts;
        end
    end

    // Publish the triple and the issue/timeout strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            device_timestamp <= '0;
            fabric_timestamp <= '0;
            cloud_timestamp  <= '0;
            timestamp_valid  <= 1'b0;
            ts_timeout       <= 1'b0;
        end else begin
            timestamp_valid <= (nxt == S_ISSUE);
            ts_timeout      <= fire_to;
            if (nxt == S_ISSUE) begin
                device_timestamp <= cap[0] ? dev_ts : hold_dev;
                fabric_timestamp <= cap[1] ? fab_ts : hold_fab;
                cloud_timestamp  <= cap[2] ? cld_ts : hold_cld;
            end
        end
    end

    // Round-robin pick of the first request at or after the pointer.
    always_comb begin
        req_ready = '0;
        grant_g   = '0;
        xfer      = 1'b0;
        if (rst_n && cg == '0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!xfer && req_valid[wrap_idx(ptr, i)]) begin
                    xfer                         = 1'b1;
                    grant_g                      = wrap_idx(ptr, i);
                    req_ready[wrap_idx(ptr, i)]  = 1'b1;
                end
            end
        end
    end

    // Chain issue register, rotation pointer and spacing counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr             <= '0;
            cg              <= '0;
            parent_chain_id <= '0;
            chain_valid     <= 1'b0;
            grant_idx       <= '0;
        end else if (xfer) begin
            parent_chain_id <= req_chain_id[int'(grant_g)*CID_W +: CID_W];
            chain_valid     <= 1'b1;
            grant_idx       <= grant_g;
            ptr             <= (grant_g == LAST_REQ) ? '0 : grant_g + PW'(1);
            cg              <= CG_LOAD;
        end else begin
            chain_valid <= 1'b0;
            if (cg != '0) cg <= cg - CGW'(1);
        end
    end

endmodule

// File: tb/tb_xenoa_temporal_sched.sv
// Directed bench for xenoa_temporal_sched: arbiter vector table
// plus hand-written triple collection, timeout and reset sequences.
module tb_xenoa_temporal_sched;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           dev_valid, fab_valid, cld_valid;
    logic [63:0]    dev_ts, fab_ts, cld_ts;
    logic           dev_ready, fab_ready, cld_ready;
    logic [3:0]     req_valid;
    logic [511:0]   req_chain_id;
    logic [3:0]     req_ready;
    logic [63:0]    device_timestamp, fabric_timestamp, cloud_timestamp;
    logic           timestamp_valid;
    logic [127:0]   parent_chain_id;
    logic           chain_valid;
    logic [1:0]     grant_idx;
    logic           ts_timeout;
    logic [2:0]     partial_mask;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0]   rv;
        logic [3:0]   rdy;
        logic         cv;
        logic [1:0]   gi;
        logic [127:0] pid;
    } arb_vec_t;

    arb_vec_t tv[22];

    xenoa_temporal_sched #(
        .NUM_REQ(4), .TS_W(64), .CID_W(128),
        .TIMEOUT(16), .TS_GAP(2), .CHAIN_GAP(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dev_valid(dev_valid), .dev_ts(dev_ts), .dev_ready(dev_ready),
        .fab_valid(fab_valid), .fab_ts(fab_ts), .fab_ready(fab_ready),
        .cld_valid(cld_valid), .cld_ts(cld_ts), .cld_ready(cld_ready),
        .req_valid(req_valid), .req_chain_id(req_chain_id),
        .req_ready(req_ready),
        .device_timestamp(device_timestamp),
        .fabric_timestamp(fabric_timestamp),
        .cloud_timestamp(cloud_timestamp),
        .timestamp_valid(timestamp_valid),
        .parent_chain_id(parent_chain_id),
        .chain_valid(chain_valid),
        .grant_idx(grant_idx),
        .ts_timeout(ts_timeout),
        .partial_mask(partial_mask)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_triple(input string nm, input logic [63:0] d,
                              input logic [63:0] f, input logic [63:0] c);
        chk({nm, "_dev"}, device_timestamp, d);
        chk({nm, "_fab"}, fabric_timestamp, f);
        chk({nm, "_cld"}, cloud_timestamp, c);
    endtask

    // Hang guard.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Stimulus and checking.
    initial begin
        bit seen_v;
        bit hit;
        int to_k;

        tv[0]  = '{4'hF, 4'h1, 1'b0, 2'd0, 128'h0};
        tv[1]  = '{4'hF, 4'h0, 1'b1, 2'd0, 128'hA};
        tv[2]  = '{4'hF, 4'h2, 1'b0, 2'd0, 128'hA};
        tv[3]  = '{4'hF, 4'h0, 1'b1, 2'd1, 128'hB};
        tv[4]  = '{4'hF, 4'h4, 1'b0, 2'd1, 128'hB};
        tv[5]  = '{4'hF, 4'h0, 1'b1, 2'd2, 128'hC};
        tv[6]  = '{4'hF, 4'h8, 1'b0, 2'd2, 128'hC};
        tv[7]  = '{4'hF, 4'h0, 1'b1, 2'd3, 128'hD};
        tv[8]  = '{4'hF, 4'h1, 1'b0, 2'd3, 128'hD};
        tv[9]  = '{4'h0, 4'h0, 1'b1, 2'd0, 128'hA};
        tv[10] = '{4'h4, 4'h4, 1'b0, 2'd0, 128'hA};
        tv[11] = '{4'h4, 4'h0, 1'b1, 2'd2, 128'hC};
        tv[12] = '{4'h4, 4'h4, 1'b0, 2'd2, 128'hC};
        tv[13] = '{4'h0, 4'h0, 1'b1, 2'd2, 128'hC};
        tv[14] = '{4'h0, 4'h0, 1'b0, 2'd2, 128'hC};
        tv[15] = '{4'h8, 4'h8, 1'b0, 2'd2, 128'hC};
        tv[16] = '{4'h1, 4'h0, 1'b1, 2'd3, 128'hD};
        tv[17] = '{4'h0, 4'h0, 1'b0, 2'd3, 128'hD};
        tv[18] = '{4'hA, 4'h2, 1'b0, 2'd3, 128'hD};
        tv[19] = '{4'hA, 4'h0, 1'b1, 2'd1, 128'hB};
        tv[20] = '{4'hA, 4'h8, 1'b0, 2'd1, 128'hB};
        tv[21] = '{4'h0, 4'h0, 1'b1, 2'd3, 128'hD};

        dev_valid = 1'b1;
        fab_valid = 1'b0;
        cld_valid = 1'b0;
        dev_ts = '0;
        fab_ts = '0;
        cld_ts = '0;
        req_valid = 4'hF;
        req_chain_id = {128'hD, 128'hC, 128'hB, 128'hA};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tsv", timestamp_valid, 0);
        chk("rst_cv", chain_valid, 0);
        chk("rst_to", ts_timeout, 0);
        chk("rst_mask", partial_mask, 0);
        chk("rst_gi", grant_idx, 0);
        chk("rst_pid", parent_chain_id, 0);
        chk("rst_dts", device_timestamp, 0);
        chk("rst_dev_rdy", dev_ready, 0);
        chk("rst_req_rdy", req_ready, 0);
        dev_valid = 1'b0;
        req_valid = 4'h0;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 22; i++) begin
            req_valid = tv[i].rv;
            @(negedge clk);
            chk($sformatf("arb%0d_rdy", i), req_ready, tv[i].rdy);
            chk($sformatf("arb%0d_cv", i), chain_valid, tv[i].cv);
            chk($sformatf("arb%0d_gi", i), grant_idx, tv[i].gi);
            chk($sformatf("arb%0d_pid", i), parent_chain_id, tv[i].pid);
            tick();
        end
        req_valid = 4'h0;

        dev_valid = 1'b1;
        dev_ts = 64'h100;
        @(negedge clk);
        chk("t1_dev_rdy", dev_ready, 1);
        tick();
        dev_valid = 1'b0;
        fab_valid = 1'b1;
        fab_ts = 64'h200;
        @(negedge clk);
        chk("t1_mask1", partial_mask, 3'b001);
        chk("t1_rdy1", {cld_ready, fab_ready, dev_ready}, 3'b110);
        tick();
        fab_valid = 1'b0;
        @(negedge clk);
        chk("t1_mask2", partial_mask, 3'b011);
        chk("t1_tsv_early", timestamp_valid, 0);
        tick();
        cld_valid = 1'b1;
        cld_ts = 64'h300;
        @(negedge clk);
        chk("t1_cld_rdy", cld_ready, 1);
        tick();
        cld_valid = 1'b0;
        @(negedge clk);
        chk("t1_tsv", timestamp_valid, 1);
        chk_triple("t1", 64'h100, 64'h200, 64'h300);
        chk("t1_rdy_issue", {cld_ready, fab_ready, dev_ready}, 3'b000);
        chk("t1_mask_clr", partial_mask, 3'b000);
        tick();
        @(negedge clk);
        chk("t1_tsv_once", timestamp_valid, 0);
        chk("t1_rdy_gap0", {cld_ready, fab_ready, dev_ready}, 3'b000);
        tick();
        @(negedge clk);
        chk("t1_rdy_gap1", {cld_ready, fab_ready, dev_ready}, 3'b000);
        tick();
        @(negedge clk);
        chk("t1_rdy_idle", {cld_ready, fab_ready, dev_ready}, 3'b111);
        tick();

        dev_valid = 1'b1;
        fab_valid = 1'b1;
        dev_ts = 64'h111;
        fab_ts = 64'h222;
        tick();
        dev_valid = 1'b0;
        fab_valid = 1'b0;
        seen_v = 1'b0;
        hit = 1'b0;
        to_k = 40;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) chk("t2_mask", partial_mask, 3'b011);
            if (timestamp_valid) seen_v = 1'b1;
            if (ts_timeout) begin
                hit = 1'b1;
                to_k = k;
                break;
            end
        end
        chk("t2_to_seen", hit, 1);
        chk("t2_to_delay", to_k, 16);
        chk("t2_no_tsv", seen_v, 0);
        chk("t2_mask_clr", partial_mask, 3'b000);
        chk_triple("t2_keep", 64'h100, 64'h200, 64'h300);
        tick();
        @(negedge clk);
        chk("t2_to_once", ts_timeout, 0);
        tick();

        dev_valid = 1'b1;
        dev_ts = 64'h411;
        tick();
        dev_valid = 1'b0;
        repeat (15) tick();
        fab_valid = 1'b1;
        cld_valid = 1'b1;
        fab_ts = 64'h422;
        cld_ts = 64'h433;
        @(negedge clk);
        chk("t5_pre_to", ts_timeout, 0);
        tick();
        fab_valid = 1'b0;
        cld_valid = 1'b0;
        @(negedge clk);
        chk("t5_tsv", timestamp_valid, 1);
        chk("t5_to", ts_timeout, 0);
        chk_triple("t5", 64'h411, 64'h422, 64'h433);
        repeat (4) tick();

        dev_valid = 1'b1;
        dev_ts = 64'h555;
        tick();
        dev_valid = 1'b0;
        @(negedge clk);
        chk("t6_mask", partial_mask, 3'b001);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_triple("t6_rst", 64'h0, 64'h0, 64'h0);
        chk("t6_tsv", timestamp_valid, 0);
        chk("t6_mask_rst", partial_mask, 0);
        chk("t6_pid", parent_chain_id, 0);
        chk("t6_gi", grant_idx, 0);
        chk("t6_cv", chain_valid, 0);
        chk("t6_to", ts_timeout, 0);
        chk("t6_dev_rdy", dev_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_v = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (timestamp_valid || ts_timeout) seen_v = 1'b1;
        end
        chk("t6_quiet", seen_v, 0);
        dev_valid = 1'b1;
        fab_valid = 1'b1;
        cld_valid = 1'b1;
        dev_ts = 64'h611;
        fab_ts = 64'h622;
        cld_ts = 64'h633;
        tick();
        dev_valid = 1'b0;
        fab_valid = 1'b0;
        cld_valid = 1'b0;
        @(negedge clk);
        chk("t6_fresh_tsv", timestamp_valid, 1);
        chk_triple("t6_fresh", 64'h611, 64'h622, 64'h633);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
